// File: rtl/palette_sequencer_if.sv
// Palette/swap load bus between palette_sequencer (master) and color_processor (slave).
interface palette_sequencer_if;
  logic        frame_start;
  logic [23:0] rgb0;
  logic [23:0] rgb1;
  logic [23:0] rgb2;
  logic [23:0] rgb3;
  logic        color_valid;
  logic        swap_h;
  logic        swap_v;
  logic [1:0]  pal_idx;
  logic        busy;

  modport master (
    input  frame_start,
    output rgb0, rgb1, rgb2, rgb3, color_valid, swap_h, swap_v, pal_idx, busy
  );

  modport slave (
    output frame_start,
    input  rgb0, rgb1, rgb2, rgb3, color_valid, swap_h, swap_v, pal_idx, busy
  );
endinterface

// File: rtl/palette_sequencer.sv
// Debounced pushbutton controller that loads palettes and swap pulses into color_processor at frame start.
// Optional AUTO_CYCLE_EN macro adds a frame counter that advances the palette every AUTO_FRAMES frames.
module palette_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int VALID_CYCLES    = 3,
  parameter int AUTO_FRAMES     = 120
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_next,
  input  logic                 btn_swap_h,
  input  logic                 btn_swap_v,
  palette_sequencer_if.master  bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(VALID_CYCLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_FRAME = 2'd1, LOAD = 2'd2} state_e;

  // Colours packed as {rgb0, rgb1, rgb2, rgb3}.
  function automatic logic [95:0] pal_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    pal_rom = {24'hF0F0F0, 24'h535353, 24'hCCCCCC, 24'h333333};
      2'd1:    pal_rom = {24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF};
      2'd2:    pal_rom = {24'h000000, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF};
      2'd3:    pal_rom = {24'h808080, 24'h400000, 24'h004000, 24'h000040};
      default: pal_rom = 96'd0;
    endcase
  endfunction

  // Button bit order: [0] next, [1] swap_h, [2] swap_v.
  logic [2:0]    sync1_q, sync2_q, level_q, level_d, rise_s;
  logic [CW-1:0] db_cnt_q [3];
  logic [CW-1:0] db_cnt_d [3];

  state_e        state_q, state_d;
  logic [LW-1:0] load_cnt_q, load_cnt_d;
  logic [1:0]    pal_idx_q, pal_idx_d;
  logic [95:0]   rgb_q, rgb_d;
  logic          color_valid_q, color_valid_d;
  logic          swap_h_q, swap_h_d, swap_v_q, swap_v_d;
  logic          busy_q, busy_d;
  logic          next_pend_q, next_pend_d;
  logic          swh_pend_q, swh_pend_d, swv_pend_q, swv_pend_d;
  logic          next_ev_s;

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      level_d[i]  = level_q[i];
      db_cnt_d[i] = db_cnt_q[i];
      rise_s[i]   = 1'b0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          level_d[i]  = sync2_q[i];
          db_cnt_d[i] = {CW{1'b0}};
          rise_s[i]   = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CW'(1);
        end
      end else begin
        db_cnt_d[i] = {CW{1'b0}};
      end
    end
  end

`ifdef AUTO_CYCLE_EN
  logic [7:0] frm_cnt_q, frm_cnt_d;
  logic       auto_ev_s;

  // Frame counter; a manual next press restarts the count.
  always_comb begin
    frm_cnt_d = frm_cnt_q;
    auto_ev_s = 1'b0;
    if (rise_s[0]) begin
      frm_cnt_d = 8'd0;
    end else if (bus.frame_start) begin
      if (frm_cnt_q == 8'(AUTO_FRAMES - 1)) begin
        frm_cnt_d = 8'd0;
        auto_ev_s = 1'b1;
      end else begin
        frm_cnt_d = frm_cnt_q + 8'd1;
      end
    end else begin
      frm_cnt_d = frm_cnt_q;
    end
  end

  // Frame counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frm_cnt_q <= 8'd0;
    else      frm_cnt_q <= frm_cnt_d;
  end

  assign next_ev_s = rise_s[0] | auto_ev_s;
`else
  assign next_ev_s = rise_s[0];
`endif

  // Load FSM, pending-request flags and frame-aligned swap pulses.
  always_comb begin
    state_d       = state_q;
    load_cnt_d    = load_cnt_q;
    pal_idx_d     = pal_idx_q;
    rgb_d         = rgb_q;
    color_valid_d = 1'b0;
    swap_h_d      = 1'b0;
    swap_v_d      = 1'b0;
    swh_pend_d    = swh_pend_q;
    swv_pend_d    = swv_pend_q;
    next_pend_d   = next_ev_s ? 1'b1 : next_pend_q;
    case (state_q)
      IDLE: begin
        if (next_pend_q) begin
          next_pend_d = 1'b0;
          pal_idx_d   = pal_idx_q + 2'd1;
          state_d     = WAIT_FRAME;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_FRAME: begin
        if (bus.frame_start) begin
          rgb_d         = pal_rom(pal_idx_q);
          color_valid_d = 1'b1;
          load_cnt_d    = LW'(1);
          state_d       = LOAD;
        end else begin
          state_d = WAIT_FRAME;
        end
      end
      LOAD: begin
        if (load_cnt_q == LW'(VALID_CYCLES)) begin
          state_d = IDLE;
        end else begin
          load_cnt_d    = load_cnt_q + LW'(1);
          color_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pending flag holds one request; extra presses while set are dropped.
    if (bus.frame_start && swh_pend_q) begin
      swap_h_d   = 1'b1;
      swh_pend_d = 1'b0;
    end else if (rise_s[1]) begin
      swh_pend_d = 1'b1;
    end else begin
      swh_pend_d = swh_pend_q;
    end
    if (bus.frame_start && swv_pend_q) begin
      swap_v_d   = 1'b1;
      swv_pend_d = 1'b0;
    end else if (rise_s[2]) begin
      swv_pend_d = 1'b1;
    end else begin
      swv_pend_d = swv_pend_q;
    end

    busy_d = (state_d != IDLE) | next_pend_d;
  end

  // State and output registers; reset leaves a palette-0 load pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q       <= 3'b000;
      sync2_q       <= 3'b000;
      level_q       <= 3'b000;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= {CW{1'b0}};
      state_q       <= WAIT_FRAME;
      load_cnt_q    <= {LW{1'b0}};
      pal_idx_q     <= 2'd0;
      rgb_q         <= 96'd0;
      color_valid_q <= 1'b0;
      swap_h_q      <= 1'b0;
      swap_v_q      <= 1'b0;
      busy_q        <= 1'b0;
      next_pend_q   <= 1'b0;
      swh_pend_q    <= 1'b0;
      swv_pend_q    <= 1'b0;
    end else begin
      sync1_q       <= {btn_swap_v, btn_swap_h, btn_next};
      sync2_q       <= sync1_q;
      level_q       <= level_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q       <= state_d;
      load_cnt_q    <= load_cnt_d;
      pal_idx_q     <= pal_idx_d;
      rgb_q         <= rgb_d;
      color_valid_q <= color_valid_d;
      swap_h_q      <= swap_h_d;
      swap_v_q      <= swap_v_d;
      busy_q        <= busy_d;
      next_pend_q   <= next_pend_d;
      swh_pend_q    <= swh_pend_d;
      swv_pend_q    <= swv_pend_d;
    end
  end

  assign bus.rgb0        = rgb_q[95:72];
  assign bus.rgb1        = rgb_q[71:48];
  assign bus.rgb2        = rgb_q[47:24];
  assign bus.rgb3        = rgb_q[23:0];
  assign bus.color_valid = color_valid_q;
  assign bus.swap_h      = swap_h_q;
  assign bus.swap_v      = swap_v_q;
  assign bus.pal_idx     = pal_idx_q;
  assign bus.busy        = busy_q;
endmodule

// File: doc/palette_sequencer.md
Name: palette_sequencer

Overview:
Controller that configures color_processor from the board pushbuttons. It debounces three buttons and steps through a fixed palette ROM. Each new 4-colour palette is loaded through the color_valid/rgb0..rgb3 load handshake. Palette loads and swap_h/swap_v pulses are applied only at frame start, so reconfiguration never happens mid-frame and the image does not tear.

Parameters:
DEBOUNCE_CYCLES, 16, number of consecutive stable synchronized samples needed to accept a button level change.
VALID_CYCLES, 3, number of cycles color_valid is held high per palette load (must be >= 1).
AUTO_FRAMES, 120, frames between automatic palette advances (used only with AUTO_CYCLE_EN).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
btn_next  in  1  raw button: advance to next palette
btn_swap_h  in  1  raw button: request horizontal swap
btn_swap_v  in  1  raw button: request vertical swap
frame_start  in  1  one-cycle pulse at start of vertical blanking
rgb0..rgb3  out  24 each  palette colours presented to color_processor
color_valid  out  1  load strobe for rgb0..rgb3
swap_h  out  1  one-cycle swap pulse
swap_v  out  1  one-cycle swap pulse
pal_idx  out  2  index of the palette currently loaded
busy  out  1  high while a load is pending or in progress

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, FSM enters WAIT_FRAME with load_pend=1, pal_idx=0. The first frame_start after reset therefore loads palette 0.
- Input conditioning:
  - Each button passes through a 2-FF synchronizer, then a debounce counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive samples that differ from it. The counter clears on any sample equal to the current level.
  - A rising edge of the debounced level produces one internal event. Falling edges produce nothing.
- Pending flags:
  - next_pend, swh_pend and swv_pend are each set by their event.
  - Each flag holds at most one request. Further events while it is set are dropped.
- Palette ROM (rgb0, rgb1, rgb2, rgb3):
  - P0 = F0F0F0, 535353, CCCCCC, 333333
  - P1 = FF0000, 00FF00, 0000FF, FFFFFF
  - P2 = 000000, FFFF00, 00FFFF, FF00FF
  - P3 = 808080, 400000, 004000, 000040
- FSM:
  - IDLE: a set next_pend clears it, sets pal_idx = pal_idx+1 (2-bit wrap, 3 -> 0) and goes to WAIT_FRAME.
  - WAIT_FRAME: on frame_start, drive rgb0..3 = ROM[pal_idx] and assert color_valid. Go to LOAD with cnt=1 (the frame_start cycle is load cycle 1).
  - LOAD: color_valid stays high until VALID_CYCLES cycles have elapsed in total, then drops and the FSM returns to IDLE. rgb0..3 hold their value after the load until the next load.
- busy = (state != IDLE) | next_pend.
- A next event arriving during WAIT_FRAME/LOAD sets next_pend. It is serviced after return to IDLE, so the index advances by one only per completed load.
- Swaps:
  - On any frame_start, a set swh_pend produces swap_h=1 for exactly that cycle and clears the flag. swv_pend/swap_v behave the same way.
  - Both swaps may pulse in the same cycle, and may coincide with the first cycle of a load.
  - Between frame_starts, swap_h and swap_v are 0.
- frame_start while in LOAD is ignored by the FSM; swap handling still applies.
- Reset asserted mid-load: color_valid drops immediately and all pending flags clear.

Optional Feature:
AUTO_CYCLE_EN:
- Defined: an 8-bit-or-wider frame counter counts frame_start pulses. When it reaches AUTO_FRAMES it sets next_pend (same path as a button, subject to the same single-request rule) and restarts from 0. A manual btn_next event also restarts the counter.
- Undefined: no counter; palettes advance only on btn_next.

Test Plan:
1. Reset release, first frame_start -> rgb0..3 = F0F0F0, 535353, CCCCCC, 333333; color_valid high exactly 3 cycles; pal_idx=0; busy falls at the end of the load.
2. btn_next pulse of 10 cycles (< DEBOUNCE_CYCLES) -> no event, pal_idx unchanged. Then a 40-cycle press plus frame_start -> P1 loaded, pal_idx=1.
3. Four accepted btn_next presses, each followed by frame_start -> pal_idx sequence 1, 2, 3, 0; the 0 load shows P0 values.
4. btn_swap_h and btn_swap_v pressed together, then frame_start -> swap_h and swap_v both high for that single cycle only; no color_valid.
5. Two btn_next events during one WAIT_FRAME -> a single index increment queued; after two frame_starts pal_idx has advanced by exactly 2.
6. rst low during the 2nd LOAD cycle -> color_valid=0 and rgb=0 immediately; after release, the next frame_start reloads P0.
7. AUTO_CYCLE_EN with AUTO_FRAMES=4: 4 frame_starts -> pal_idx 0 -> 1 on the following load, with no button activity.
